spi_master_slave: RTL and testbench

Single-clock 8-bit SPI master bridging the register/control side of the design to an external serial peripheral. A start pulse runs one 8-bit full-duplex frame: a staged TX byte (or 0x00) is shifted out on MOSI MSB-first while 8 MISO bits are captured. SCLK rate is set by a 2-bit divider select. Completion is reported through `rx_valid` and `tx_done`.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_clk_div.sv | 45 ++++
 rtl/spi_master_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_master_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master.
//   DATA_W     - frame width (8 bits)
//   HCNT_W     - width of the half-period counter
//   state_t    - frame sequencer states
//   half_term  - maps the 2-bit divider select to the terminal count (H-1)
package spi_pkg;

   localparam int DATA_W = 8;
   localparam int HCNT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL,
      DONE
   } state_t;

   // Terminal counts of the half-period counter: the counter runs 0..H-1,
   // so the stored value is H-1 for H = 2 / 4 / 8 / 16 clk cycles.
   localparam logic [HCNT_W-1:0] HALF_TERM_2  = 4'd1;
   localparam logic [HCNT_W-1:0] HALF_TERM_4  = 4'd3;
   localparam logic [HCNT_W-1:0] HALF_TERM_8  = 4'd7;
   localparam logic [HCNT_W-1:0] HALF_TERM_16 = 4'd15;

   function automatic logic [HCNT_W-1:0] half_term(input logic [1:0] sel);
      logic [HCNT_W-1:0] term;
      term = HALF_TERM_2;
      case (sel)
         2'b00:   term = HALF_TERM_2;
         2'b01:   term = HALF_TERM_4;
         2'b10:   term = HALF_TERM_8;
         default: term = HALF_TERM_16;
      endcase
      return term;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter for the SPI master.
//   clk, reset - system clock, synchronous active-high reset
//   run        - counter enable; held low the counter sits at zero
//   xfer       - high while SCLK is toggling; turns ticks into rise/fall
//   term       - terminal count (H-1), latched by the parent at frame start
//   tick       - one-cycle strobe at the end of every half-period
//   rise, fall - tick qualified as an SCLK rising / falling edge
module spi_clk_div
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              xfer,
   input  logic [HCNT_W-1:0] term,
   output logic              tick,
   output logic              rise,
   output logic              fall
);

   logic [HCNT_W-1:0] cnt;
   // Mirrors the SCLK level: 0 means the next transfer tick is a rising edge.
   logic              phase;

   assign tick = run && (cnt == term);
   assign rise = tick && xfer && !phase;
   assign fall = tick && xfer && phase;

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         if (cnt == term) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (xfer && tick) begin
            phase <= !phase;
         end
      end
   end

endmodule

// File: rtl/spi_master_slave.sv
// spi_master_slave: 8-bit SPI mode-1 (CPOL=0, CPHA=1) master, MSB first.
//   clk, reset       - system clock, synchronous active-high reset
//   slave_rx_start   - pulse: run one full-duplex frame (only while idle)
//   slave_tx_start   - pulse: stage input_reg_data for the next frame
//   input_reg_data   - byte to stage
//   dout_miso        - serial data from the peripheral
//   freq_control     - SCLK half-period select (2/4/8/16 clk), latched per frame
//   cs_bar, sclk,
//   din_mosi         - SPI bus outputs (all registered)
//   output_reg_data  - last received byte
//   rx_valid         - level: output_reg_data holds a completed frame
//   tx_done          - pulse: the finished frame carried a staged byte
//   debug_state      - current sequencer state
//
// Handshake: a start pulse is accepted only in IDLE and is not queued.
// rx_valid drops on the accepted start and rises together with cs_bar and
// tx_done once the frame completes; it then holds until the next accepted
// start. slave_tx_start is accepted in every state and the staged byte is
// consumed by the next frame start (a same-cycle stage wins).
module spi_master_slave
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              slave_rx_start,
   input  logic              slave_tx_start,
   input  logic [DATA_W-1:0] input_reg_data,
   input  logic              dout_miso,
   input  logic [1:0]        freq_control,
   output logic              cs_bar,
   output logic              sclk,
   output logic              din_mosi,
   output logic [DATA_W-1:0] output_reg_data,
   output logic              rx_valid,
   output logic              tx_done,
   output state_t            debug_state
);

   state_t            state;
   logic [DATA_W-1:0] hold_reg;
   logic              tx_pending;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [HCNT_W-1:0] term;
   logic              frame_staged;
   logic [2:0]        bit_cnt;

   logic run;
   logic xfer;
   logic tick;
   logic rise;
   logic fall;

   assign run         = (state == LEAD) || (state == XFER) || (state == TRAIL);
   assign xfer        = (state == XFER);
   assign debug_state = state;

   spi_clk_div u_clk_div (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .xfer  (xfer),
      .term  (term),
      .tick  (tick),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         cs_bar          <= 1'b1;
         sclk            <= 1'b0;
         din_mosi        <= 1'b0;
         output_reg_data <= '0;
         rx_valid        <= 1'b0;
         tx_done         <= 1'b0;
         hold_reg        <= '0;
         tx_pending      <= 1'b0;
         tx_shift        <= '0;
         rx_shift        <= '0;
         term            <= '0;
         frame_staged    <= 1'b0;
         bit_cnt         <= '0;
      end else begin
         tx_done <= 1'b0;

         if (slave_tx_start) begin
            hold_reg   <= input_reg_data;
            tx_pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (slave_rx_start) begin
                  state    <= LEAD;
                  cs_bar   <= 1'b0;
                  rx_valid <= 1'b0;
                  term     <= half_term(freq_control);
                  bit_cnt  <= '0;
                  // A stage arriving in the start cycle bypasses the holding
                  // register so it rides this frame.
                  if (slave_tx_start) begin
                     tx_shift <= input_reg_data;
                  end else if (tx_pending) begin
                     tx_shift <= hold_reg;
                  end else begin
                     tx_shift <= '0;
                  end
                  frame_staged <= slave_tx_start || tx_pending;
                  // Overrides the staging update above: the byte is consumed.
                  tx_pending   <= 1'b0;
               end
            end

            LEAD: begin
               if (tick) begin
                  state <= XFER;
               end
            end

            XFER: begin
               if (rise) begin
                  sclk     <= 1'b1;
                  din_mosi <= tx_shift[DATA_W-1];
                  tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
               end
               if (fall) begin
                  sclk     <= 1'b0;
                  rx_shift <= {rx_shift[DATA_W-2:0], dout_miso};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= TRAIL;
                  end
               end
            end

            TRAIL: begin
               if (tick) begin
                  state <= DONE;
               end
            end

            DONE: begin
               cs_bar          <= 1'b1;
               din_mosi        <= 1'b0;
               output_reg_data <= rx_shift;
               rx_valid        <= 1'b1;
               tx_done         <= frame_staged;
               state           <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_slave.sv
// tb_spi_master_slave: directed bench for spi_master_slave. A frame-level
// model predicts every bus output from the frame start time, half-period
// and bytes; a compare process checks it each cycle, and literal
// expectations pin timing and data of each directed frame.
module tb_spi_master_slave;
   import spi_pkg::*;

   logic       clk;
   logic       reset;
   logic       slave_rx_start;
   logic       slave_tx_start;
   logic [7:0] input_reg_data;
   logic       dout_miso = 1'b0;
   logic [1:0] freq_control;
   logic       cs_bar;
   logic       sclk;
   logic       din_mosi;
   logic [7:0] output_reg_data;
   logic       rx_valid;
   logic       tx_done;
   state_t     dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   spi_master_slave dut (
      .clk             (clk),
      .reset           (reset),
      .slave_rx_start  (slave_rx_start),
      .slave_tx_start  (slave_tx_start),
      .input_reg_data  (input_reg_data),
      .dout_miso       (dout_miso),
      .freq_control    (freq_control),
      .cs_bar          (cs_bar),
      .sclk            (sclk),
      .din_mosi        (din_mosi),
      .output_reg_data (output_reg_data),
      .rx_valid        (rx_valid),
      .tx_done         (tx_done),
      .debug_state     (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- frame-level model ----------------
   // A frame accepted at edge t0 keeps cs_bar low for edges t0..t0+18H and
   // completes at edge t0+18H+1. SCLK is high during half-periods 2,4,..,16
   // (counted in units of H from t0); bit k of MOSI is presented from the
   // k-th rise, MSB first.
   int         e = 0;
   int         m_t0 = 0;
   int         m_h = 2;
   bit         m_active = 1'b0;
   bit         m_pending = 1'b0;
   bit         m_rx_valid = 1'b0;
   bit         m_tx_done = 1'b0;
   bit         m_staged = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] m_tx = 8'h00;
   logic [7:0] m_rx = 8'h00;
   logic [7:0] m_out = 8'h00;
   logic [7:0] miso_byte = 8'h00;

   function automatic int half_of(input logic [1:0] f);
      return 2 << f;
   endfunction

   function automatic logic exp_sclk(input int t, input int h);
      return (t >= 2 * h) && (t < 17 * h) && (((t / h) % 2) == 0);
   endfunction

   function automatic logic exp_mosi(input int t, input int h, input logic [7:0] b);
      int k;
      logic [7:0] v;
      if (t < 2 * h) return 1'b0;
      k = (t - 2 * h) / (2 * h);
      if (k > 7) k = 7;
      v = b;
      return v[7 - k];
   endfunction

   always @(posedge clk) begin : model
      bit was_active;
      e = e + 1;
      m_tx_done = 1'b0;
      if (reset) begin
         m_active   = 1'b0;
         m_pending  = 1'b0;
         m_rx_valid = 1'b0;
         m_out      = 8'h00;
      end else begin
         was_active = m_active;
         if (m_active && (e - m_t0 == 18 * m_h + 1)) begin
            m_active   = 1'b0;
            m_out      = m_rx;
            m_rx_valid = 1'b1;
            m_tx_done  = m_staged;
         end
         if (!was_active && slave_rx_start) begin
            m_active   = 1'b1;
            m_t0       = e;
            m_h        = half_of(freq_control);
            m_tx       = slave_tx_start ? input_reg_data : (m_pending ? m_hold : 8'h00);
            m_staged   = slave_tx_start || m_pending;
            m_pending  = 1'b0;
            m_rx_valid = 1'b0;
            m_rx       = miso_byte;
         end else if (slave_tx_start) begin
            m_hold    = input_reg_data;
            m_pending = 1'b1;
         end
      end
   end

   // ---------------- bus monitor / MISO responder ----------------
   int         n_cyc = 0;
   int         fall_cyc = 0;
   int         rv_cyc = 0;
   int         txd_cyc = 0;
   int         txd_cnt = 0;
   int         n_rise = 0;
   int         run_len = 0;
   int         hi_min = 0;
   int         hi_max = 0;
   int         lo_min = 0;
   int         lo_max = 0;
   bit         rv_seen = 1'b0;
   logic       prev_cs = 1'b1;
   logic       prev_sclk = 1'b0;
   logic       prev_rv = 1'b0;
   logic [7:0] mosi_cap = 8'h00;
   logic [7:0] miso_sh = 8'h00;

   always @(negedge clk) begin
      n_cyc = n_cyc + 1;
      if (prev_cs === 1'b1 && cs_bar === 1'b0) begin
         fall_cyc = n_cyc;
         rv_seen  = 1'b0;
         txd_cnt  = 0;
         n_rise   = 0;
         mosi_cap = 8'h00;
         miso_sh  = miso_byte;
         run_len  = 0;
         hi_min   = 1000;
         hi_max   = 0;
         lo_min   = 1000;
         lo_max   = 0;
      end
      if (cs_bar === 1'b0) begin
         if (sclk !== prev_sclk) begin
            if (prev_sclk === 1'b1) begin
               if (run_len < hi_min) hi_min = run_len;
               if (run_len > hi_max) hi_max = run_len;
            end else if (n_rise > 0) begin
               if (run_len < lo_min) lo_min = run_len;
               if (run_len > lo_max) lo_max = run_len;
            end
            run_len = 1;
            if (sclk === 1'b1) begin
               n_rise    = n_rise + 1;
               mosi_cap  = {mosi_cap[6:0], din_mosi};
               dout_miso = miso_sh[7];
               miso_sh   = {miso_sh[6:0], 1'b0};
            end
         end else begin
            run_len = run_len + 1;
         end
      end
      if (prev_rv === 1'b0 && rx_valid === 1'b1) begin
         rv_seen = 1'b1;
         rv_cyc  = n_cyc;
      end
      if (tx_done === 1'b1) begin
         txd_cnt = txd_cnt + 1;
         txd_cyc = n_cyc;
      end
      prev_cs   = cs_bar;
      prev_sclk = sclk;
      prev_rv   = rx_valid;
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic compare_loop();
      int t;
      forever begin
         @(negedge clk);
         if (check_en) begin
            t = e - m_t0;
            chk("cs_bar", {15'd0, cs_bar}, m_active ? 16'd0 : 16'd1);
            chk("sclk", {15'd0, sclk}, {15'd0, m_active ? exp_sclk(t, m_h) : 1'b0});
            chk("din_mosi", {15'd0, din_mosi}, {15'd0, m_active ? exp_mosi(t, m_h, m_tx) : 1'b0});
            chk("output_reg_data", {8'd0, output_reg_data}, {8'd0, m_out});
            chk("rx_valid", {15'd0, rx_valid}, {15'd0, m_rx_valid});
            chk("tx_done", {15'd0, tx_done}, {15'd0, m_tx_done});
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_tx(input logic [7:0] d);
      input_reg_data = d;
      slave_tx_start = 1'b1;
      step();
      slave_tx_start = 1'b0;
   endtask

   task automatic start_frame(input logic [1:0] f, input logic [7:0] mb);
      freq_control   = f;
      miso_byte      = mb;
      slave_rx_start = 1'b1;
      step();
      slave_rx_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 400; i++) begin
         step();
         if (rv_seen) break;
      end
      chk(name, {15'd0, rv_seen}, 16'd1);
      step();
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset          = 1'b1;
      slave_rx_start = 1'b0;
      slave_tx_start = 1'b0;
      input_reg_data = 8'h00;
      freq_control   = 2'b00;
      fork
         compare_loop();
      join_none

      // Reset held 40 cycles, with start pulses that must be ignored.
      step();
      check_en = 1'b1;
      for (int i = 0; i < 39; i++) begin
         slave_rx_start = (i == 10) || (i == 25);
         slave_tx_start = (i == 10);
         input_reg_data = 8'h99;
         step();
      end
      slave_rx_start = 1'b0;
      slave_tx_start = 1'b0;
      chk("rst_cs_bar", {15'd0, cs_bar}, 16'd1);
      chk("rst_sclk", {15'd0, sclk}, 16'd0);
      chk("rst_mosi", {15'd0, din_mosi}, 16'd0);
      chk("rst_out", {8'd0, output_reg_data}, 16'h00);
      chk("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
      chk("rst_tx_done", {15'd0, tx_done}, 16'd0);
      chk("rst_state", {13'd0, dbg_state}, {13'd0, IDLE});
      reset = 1'b0;
      repeat (5) step();
      chk("post_rst_idle", {15'd0, cs_bar}, 16'd1);

      // Frame 1: H=2, staged 0xF1, MISO 0x00.
      pulse_tx(8'hF1);
      start_frame(2'b00, 8'h00);
      wait_done("f1_done");
      chk("f1_mosi_bits", {8'd0, mosi_cap}, 16'h00F1);
      chk("f1_rises", n_rise[15:0], 16'd8);
      chk("f1_out", {8'd0, output_reg_data}, 16'h0000);
      chk("f1_rx_valid", {15'd0, rx_valid}, 16'd1);
      chk("f1_tx_done_cnt", txd_cnt[15:0], 16'd1);
      chk("f1_tx_done_lat", 16'(txd_cyc - fall_cyc), 16'd37);

      // Frame 2: nothing staged, MISO 0x05.
      start_frame(2'b00, 8'h05);
      wait_done("f2_done");
      chk("f2_mosi_bits", {8'd0, mosi_cap}, 16'h0000);
      chk("f2_out", {8'd0, output_reg_data}, 16'h0005);
      chk("f2_tx_done_cnt", txd_cnt[15:0], 16'd0);

      // Frame 3: H=16.
      start_frame(2'b11, 8'hC3);
      wait_done("f3_done");
      chk("f3_rv_lat", 16'(rv_cyc - fall_cyc), 16'd289);
      chk("f3_hi_min", hi_min[15:0], 16'd16);
      chk("f3_hi_max", hi_max[15:0], 16'd16);
      chk("f3_lo_min", lo_min[15:0], 16'd16);
      chk("f3_lo_max", lo_max[15:0], 16'd16);
      chk("f3_out", {8'd0, output_reg_data}, 16'h00C3);

      // Frame 4: H=4, perturbed mid-XFER (start, divider change, stage 0xA5).
      start_frame(2'b01, 8'h5A);
      repeat (20) step();
      slave_rx_start = 1'b1;
      freq_control   = 2'b00;
      step();
      slave_rx_start = 1'b0;
      pulse_tx(8'hA5);
      wait_done("f4_done");
      chk("f4_rv_lat", 16'(rv_cyc - fall_cyc), 16'd73);
      chk("f4_hi_min", hi_min[15:0], 16'd4);
      chk("f4_hi_max", hi_max[15:0], 16'd4);
      chk("f4_mosi_bits", {8'd0, mosi_cap}, 16'h0000);
      chk("f4_tx_done_cnt", txd_cnt[15:0], 16'd0);
      chk("f4_out", {8'd0, output_reg_data}, 16'h005A);

      // Frame 5: H=8, carries the byte staged during frame 4.
      start_frame(2'b10, 8'h81);
      wait_done("f5_done");
      chk("f5_mosi_bits", {8'd0, mosi_cap}, 16'h00A5);
      chk("f5_tx_done_cnt", txd_cnt[15:0], 16'd1);
      chk("f5_rv_lat", 16'(rv_cyc - fall_cyc), 16'd145);
      chk("f5_out", {8'd0, output_reg_data}, 16'h0081);

      // Frame 6: aborted by reset mid-XFER after staging 0x77.
      start_frame(2'b00, 8'hFF);
      repeat (10) step();
      pulse_tx(8'h77);
      reset = 1'b1;
      step();
      chk("abort_cs_bar", {15'd0, cs_bar}, 16'd1);
      chk("abort_sclk", {15'd0, sclk}, 16'd0);
      chk("abort_rx_valid", {15'd0, rx_valid}, 16'd0);
      chk("abort_tx_done", {15'd0, tx_done}, 16'd0);
      reset = 1'b0;
      repeat (3) step();
      chk("abort_no_tx_done", txd_cnt[15:0], 16'd0);
      chk("abort_no_rv", {15'd0, rv_seen}, 16'd0);

      // Frame 7: staged byte was discarded, so 0x00 goes out.
      start_frame(2'b00, 8'h3C);
      wait_done("f7_done");
      chk("f7_mosi_bits", {8'd0, mosi_cap}, 16'h0000);
      chk("f7_tx_done_cnt", txd_cnt[15:0], 16'd0);
      chk("f7_out", {8'd0, output_reg_data}, 16'h003C);

      repeat (3) step();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
